// File: rtl/chdr_sid_stamp.sv
// CHDR transmit-side SID stamper: rewrites the header word of each packet with the
// destination SID and a running 12-bit sequence number, then registers through a 2-entry skid buffer.
module chdr_sid_stamp #(
  parameter logic [15:0] DEFAULT_SID = 16'h00A0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [15:0] dst_sid,
  input  logic        dst_sid_valid,
  input  logic [64:0] i_tdata,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [64:0] o_tdata,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [11:0] seqnum,
  output logic [15:0] count
);

  typedef enum logic {HEADER, BODY} state_t;

  state_t      state, state_next;
  logic [1:0]  occ, occ_next;
  logic [64:0] head, tail, stamped;
  logic [15:0] sid;
  logic [11:0] seq;
  logic        rst, push, pop;

  assign rst      = reset | clear;
  assign push     = i_tvalid & i_tready;
  assign pop      = o_tvalid & o_tready;
  assign o_tvalid = (occ != 2'd0);
  assign o_tdata  = head;
  assign seqnum   = seq;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_next = state;
    stamped    = i_tdata;
    if (state == HEADER) begin
      stamped[15:0]  = sid;
      stamped[59:48] = seq;
    end
    // tlast always returns to HEADER; any other accepted word leaves us mid-packet.
    if (push) state_next = i_tdata[64] ? HEADER : BODY;
  end

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HEADER;
      seq   <= 12'd0;
      sid   <= DEFAULT_SID;
      count <= 16'd0;
    end else begin
      state <= state_next;
      if (push && state == HEADER) seq <= seq + 12'd1;
      // The SID register is read before this edge, so a coincident header keeps the old SID.
      if (dst_sid_valid) sid <= dst_sid;
      if (pop && head[64]) count <= count + 16'd1;
    end
  end

  // NOTE: the data registers are reset too, because o_tdata must read zero after reset/clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      i_tready <= 1'b1;
      head     <= '0;
      tail     <= '0;
    end else begin
      occ      <= occ_next;
      // Ready is derived from next occupancy and registered, isolating it from o_tready.
      i_tready <= (occ_next != 2'd2);
      case (occ)
        2'd0: if (push) head <= stamped;
        2'd1: begin
          if (push && pop)  head <= stamped;
          else if (push)    tail <= stamped;
        end
        2'd2: if (pop) head <= tail;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chdr_sid_stamp.sv
// Self-checking bench for chdr_sid_stamp: directed scenarios plus randomized traffic
// compared against a packet-level reference model of the stamping rules.
module tb_chdr_sid_stamp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] dst_sid = '0;
  logic        dst_sid_valid = 1'b0;
  logic [64:0] i_tdata = '0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [64:0] o_tdata;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic [11:0] seqnum;
  logic [15:0] count;

  chdr_sid_stamp dut (
    .clk(clk), .reset(reset), .clear(clear),
    .dst_sid(dst_sid), .dst_sid_valid(dst_sid_valid),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .seqnum(seqnum), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: expected output words with their push cycle.
  typedef struct {
    logic [64:0] data;
    bit          hdr;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_in_pkt;
  int          m_seq;
  logic [15:0] m_sid;
  int          count_exp;
  int          acc_cnt = 0;
  int          cyc = 0;
  bit          lat_check = 0;
  bit          hold_valid;
  logic [64:0] hold_data;
  logic [64:0] last_hdr_out = '0;

  bit rand_ready  = 0;
  bit ready_fixed = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready driver; also confirms i_tready does not move when o_tready does.
  always @(posedge clk) begin
    logic prev;
    #1;
    prev = i_tready;
    o_tready = rand_ready ? 1'($urandom % 2) : ready_fixed;
    #1;
    check("itready_comb", i_tready, prev);
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset || clear) begin
      exp_q.delete();
      m_in_pkt   = 0;
      m_seq      = 0;
      m_sid      = 16'h00A0;
      count_exp  = 0;
      hold_valid = 0;
    end else begin
      if (hold_valid) begin
        check("stall_valid", o_tvalid, 1);
        check("stall_data", o_tdata, hold_data);
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("out_word", o_tdata, e.data);
          if (lat_check) check("latency", cyc - e.cyc, 1);
          if (e.hdr) last_hdr_out = o_tdata;
          if (e.data[64]) count_exp++;
        end
      end
      if (i_tvalid && i_tready) begin
        e.data = i_tdata;
        e.hdr  = !m_in_pkt;
        e.cyc  = cyc;
        if (e.hdr) begin
          e.data[15:0]  = m_sid;
          e.data[59:48] = 12'(m_seq);
          m_seq = (m_seq + 1) % 4096;
        end
        m_in_pkt = !i_tdata[64];
        exp_q.push_back(e);
        acc_cnt++;
      end
      if (dst_sid_valid) m_sid = dst_sid;
      hold_valid = o_tvalid && !o_tready;
      hold_data  = o_tdata;
    end
  end

  task automatic send(input logic [64:0] w, input bit sid_pulse = 0, input logic [15:0] sid = 16'h0);
    int n = 0;
    i_tdata = w;
    i_tvalid = 1'b1;
    dst_sid_valid = sid_pulse;
    dst_sid = sid;
    @(negedge clk);
    while (!i_tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) check("send_timeout", n, 0);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    dst_sid_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit rand_gaps);
    logic [63:0] d;
    for (int k = 0; k < len; k++) begin
      d = {$urandom, $urandom};
      send({1'(k == len - 1), d});
      if (rand_gaps && ($urandom % 10) < 3) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_tvalid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("drain_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, acc0;
    do_reset();
    @(negedge clk);
    check("rst_itready", i_tready, 1);
    check("rst_otvalid", o_tvalid, 0);
    check("rst_otdata", o_tdata, 0);
    check("rst_seqnum", seqnum, 0);
    check("rst_count", count, 0);
    @(posedge clk);
    #1;

    // Three 4-word packets, full throughput, 1-cycle latency.
    lat_check = 1;
    t0 = cyc;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++)
        send(k == 0 ? {1'b0, 64'h0000_0000_0000_1234}
                    : {1'(k == 3), 64'hB0D0_0000_0000_0000 + 64'(p * 4 + k)});
    check("throughput", cyc - t0, 12);
    drain();
    lat_check = 0;
    check("t1_last_hdr", last_hdr_out, 65'h0_0002_0000_0000_00A0);
    check("t1_count", count, 3);
    check("t1_seqnum", seqnum, 3);

    // SID load mid-packet, then coincident with a header.
    send({1'b0, 64'h0000_0000_0000_1234});
    send({1'b0, 64'h1111_2222_3333_4444}, 1, 16'h00B0);
    send({1'b0, 64'h5555_6666_7777_8888});
    send({1'b1, 64'h9999_AAAA_BBBB_CCCC});
    drain();
    check("sid_mid_pkt_old", last_hdr_out[15:0], 16'h00A0);
    send_pkt(3, 0);
    drain();
    check("sid_after_load", last_hdr_out[15:0], 16'h00B0);
    send({1'b0, 64'h0000_0000_0000_5678}, 1, 16'h00C0);
    send({1'b1, 64'h0000_0000_0000_0001});
    drain();
    check("sid_coincident", last_hdr_out[15:0], 16'h00B0);
    send_pkt(1, 0);
    drain();
    check("sid_next_hdr", last_hdr_out[15:0], 16'h00C0);

    // 4097 single-word packets: sequence wraps.
    do_reset();
    lat_check = 1;
    for (int i = 0; i < 4097; i++) send({1'b1, $urandom, $urandom});
    drain();
    lat_check = 0;
    check("wrap_last_seq", last_hdr_out[59:48], 0);
    check("wrap_seqnum", seqnum, 1);
    check("wrap_count", count, 4097);

    // Randomized traffic with random sink backpressure.
    rand_ready = 1;
    for (int p = 0; p < 1000; p++) send_pkt($urandom_range(1, 6), 1);
    rand_ready = 0;
    ready_fixed = 1;
    drain();
    check("rand_count", count, 16'(count_exp));
    check("rand_seqnum", seqnum, 12'(m_seq));

    // Sink stalled for 10 cycles: exactly two words taken.
    ready_fixed = 0;
    @(posedge clk);
    #2;
    acc0 = acc_cnt;
    fork
      send_pkt(4, 0);
    join_none
    repeat (10) @(negedge clk);
    check("stall_accepts", acc_cnt - acc0, 2);
    check("stall_itready", i_tready, 0);
    ready_fixed = 1;
    wait fork;
    drain();
    check("stall_all_out", acc_cnt - acc0, 4);

    // Clear on word 2 of a 5-word packet.
    send({1'b0, 64'hC1EA_0000_0000_0001});
    i_tdata = {1'b0, 64'hC1EA_0000_0000_0002};
    i_tvalid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    i_tvalid = 1'b0;
    @(negedge clk);
    check("clr_otvalid", o_tvalid, 0);
    check("clr_seqnum", seqnum, 0);
    check("clr_count", count, 0);
    @(posedge clk);
    #1;
    send({1'b0, 64'hFFFF_0000_0000_FFFF});
    send({1'b1, 64'h0000_0000_0000_0042});
    drain();
    check("clr_new_hdr", last_hdr_out, 65'h0_F000_0000_0000_00A0);
    check("clr_count_after", count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chdr_sid_stamp.md
# chdr_sid_stamp

Transmit-side counterpart to the ingress SID filter. Accepts 65-bit packet streams (bit 64 = tlast, bits 63:0 = data) from a local source and rewrites the first (header) word of each packet: destination SID into bits 15:0 and a running 12-bit sequence number into bits 59:48. Its output therefore carries a SID the far-end filter accepts. Output is registered through a two-entry skid buffer to break combinational paths between source and link.

## Interface
- DEFAULT_SID, 16'h00A0, destination SID used after reset/clear until `dst_sid_valid` is pulsed
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- clear  in  1  synchronous, active-high soft clear; same effect as reset
- dst_sid  in  16  new destination SID
- dst_sid_valid  in  1  single-cycle strobe; loads `dst_sid` into the SID register
- i_tdata  in  65  input packet word, bit 64 = last
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  65  stamped output word
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- seqnum  out  12  sequence number to be stamped on the next packet
- count  out  16  packets fully emitted (tlast accepted on output), wraps 16'hFFFF -> 0

## Operation
- State machine, two states: HEADER (reset state) and BODY.
  - HEADER: on input accept (i_tvalid & i_tready), the word is stamped. Bits 15:0 = SID register, bits 59:48 = seq counter, all other bits pass unchanged, including 64 and 63:60. If bit 64 = 1 (single-word packet), stay in HEADER. Otherwise go to BODY. Seq counter increments on every header accept.
  - BODY: words pass unchanged. On accept with bit 64 = 1, go to HEADER.
- SID register:
  - Reset/clear value is DEFAULT_SID.
  - Loaded on `dst_sid_valid`.
  - A load takes effect from the next header accepted after the load cycle. A load in the same cycle as a header accept does not affect that header; the header uses the old SID.
  - A load mid-packet never alters words already stamped.
- Seq counter: 12-bit, reset/clear to 0, wraps 4095 -> 0. `seqnum` is the counter value.
- count: increments when o_tvalid & o_tready & o_tdata[64].
- Packets are never dropped, reordered, or truncated. There is no length check.

## Timing
- Skid buffer (two 65-bit entries):
  - i_tready = 1 when fewer than 2 entries are occupied. This is registered, with no combinational path from o_tready.
  - o_tvalid = 1 when at least 1 entry is occupied.
  - o_tdata is driven from the head register.
- Latency: an input word accepted at edge N is presented on o_tdata after edge N, i.e. o_tvalid is high in cycle N+1 when the buffer was empty.
- Throughput: with o_tready held high, one word per cycle sustained, no bubbles.
- Simultaneous push and pop with one entry occupied: occupancy stays 1 and i_tready stays high.
- Full (2 entries), no pop: i_tready = 0. The input must hold its word, and the state machine does not advance.
- o_tdata must stay stable while o_tvalid & !o_tready.
- Reset/clear values:
  - i_tready = 1 from the first cycle after reset deasserts.
  - o_tvalid = 0, o_tdata = 0.
  - state = HEADER, seqnum = 0, count = 0, SID = DEFAULT_SID.
- Reset/clear mid-packet: buffered words are discarded, no partial-packet tail is emitted, and the next accepted word is treated as a header.

## Test plan
- Three 4-word packets (header 64'h0000_0000_0000_1234), o_tready = 1, no `dst_sid_valid` -> headers emitted with [15:0] = 16'h00A0 and [59:48] = 0, 1, 2. Body words are bit-exact, one word per cycle, 1-cycle latency. count = 3.
- Pulse `dst_sid_valid` with dst_sid = 16'h00B0 during a packet's second word -> that packet is unchanged, next header has [15:0] = 16'h00B0. Pulse coincident with a header accept -> that header keeps the old SID.
- Stream of single-word packets (bit 64 = 1 on each) -> every word stamped, seq increments every cycle. After 4097 packets the last header has seq 0 and seqnum = 1.
- Random o_tready (50%) and random i_tvalid over 1000 packets -> output equals expected stamped stream, no loss or duplication. o_tdata is stable while stalled. i_tready never depends combinationally on o_tready.
- o_tready = 0 for 10 cycles -> exactly 2 words accepted, then i_tready = 0. Release -> both words drain in order and throughput resumes.
- Assert clear on word 2 of a 5-word packet -> o_tvalid = 0 next cycle, seqnum = 0, count = 0. The next input word is stamped as a header with seq 0 and SID 16'h00A0.
